// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency meter checker.
package freq_meter_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED,
    STALLED
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] lo;
    logic [CNT_W-1:0] hi;
  } window_t;

  // Widen [low, high] by hyst, saturating at 0 and all-ones instead of wrapping.
  function automatic window_t hyst_window(input logic [CNT_W-1:0] low,
                                          input logic [CNT_W-1:0] high,
                                          input logic [CNT_W-1:0] hyst);
    logic [CNT_W:0] lo_ext;
    logic [CNT_W:0] hi_ext;
    window_t        win;
    lo_ext = {1'b0, low} - {1'b0, hyst};
    hi_ext = {1'b0, high} + {1'b0, hyst};
    win.lo = lo_ext[CNT_W] ? '0 : lo_ext[CNT_W-1:0];
    win.hi = hi_ext[CNT_W] ? '1 : hi_ext[CNT_W-1:0];
    return win;
  endfunction

endpackage

// File: rtl/freq_run_counter.sv
// Saturating consecutive-event counter with a threshold-reached flag.
module freq_run_counter #(
  parameter int unsigned THRESH = 4,
  parameter int unsigned W      = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [W-1:0] ThrM1  = W'(THRESH - 1);
  localparam logic [W-1:0] CntMax = {W{1'b1}};

  logic [W-1:0] count_q;

  // hit marks the increment that lands on the threshold; the owner clears on it.
  assign hit = inc && (count_q >= ThrM1);

  // Run length, clear dominant over increment, holds at all-ones.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != CntMax)) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/freq_meter_checker.sv
// Window/hysteresis classifier, lock qualifier, stall detector and min/max
// tracker for period-count readouts from the frequency meter.
module freq_meter_checker
  import freq_meter_pkg::*;
#(
  parameter logic [CNT_W-1:0] LOW_LIMIT  = 32'd1000,
  parameter logic [CNT_W-1:0] HIGH_LIMIT = 32'd2000,
  parameter logic [CNT_W-1:0] HYST       = 32'd50,
  parameter int unsigned      GOOD_CNT   = 4,
  parameter int unsigned      BAD_CNT    = 2,
  parameter int unsigned      TIMEOUT    = 200000
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic [CNT_W-1:0] readout,
  input  logic             readout_strb,
  output logic             freq_ok,
  output logic             freq_low,
  output logic             freq_high,
  output logic             stalled,
  output logic             lock_lost_strb,
  output logic [CNT_W-1:0] min_cnt,
  output logic [CNT_W-1:0] max_cnt
);

  localparam window_t          Win    = hyst_window(LOW_LIMIT, HIGH_LIMIT, HYST);
  localparam logic [CNT_W-1:0] TmoM1  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TmoSat = CNT_W'(TIMEOUT);

  state_e           state_q;
  logic [CNT_W-1:0] tmo_q;
  logic             raw_low_q;

  logic below, above, in_raw, in_hyst;
  logic strb, acq_like, timed_run, stall_go;
  logic good_inc, good_clr, good_hit;
  logic bad_inc, bad_clr, bad_hit;

  // Sample classification and event decode for this cycle.
  always_comb begin
    below     = readout < LOW_LIMIT;
    above     = readout > HIGH_LIMIT;
    in_raw    = !below && !above;
    in_hyst   = (readout >= Win.lo) && (readout <= Win.hi);
    // A strobe that coincides with clear is discarded.
    strb      = readout_strb && !clear;
    acq_like  = (state_q == IDLE) || (state_q == ACQUIRE) || (state_q == STALLED);
    timed_run = (state_q == ACQUIRE) || (state_q == LOCKED);
    // A strobe on the expiry cycle wins over the stall.
    stall_go  = timed_run && !readout_strb && !clear && (tmo_q >= TmoM1);

    // Samples taken from IDLE/STALLED count as ACQUIRE's first sample.
    good_inc  = strb && acq_like && in_raw;
    good_clr  = clear || !acq_like || (strb && !in_raw) || good_hit || stall_go ||
                ((state_q != ACQUIRE) && !strb);
    bad_inc   = strb && (state_q == LOCKED) && !in_hyst;
    bad_clr   = clear || (state_q != LOCKED) || (strb && in_hyst) || bad_hit || stall_go;
  end

  freq_run_counter #(
    .THRESH(GOOD_CNT)
  ) u_good_run (
    .clk (clk),
    .nrst(nrst),
    .inc (good_inc),
    .clr (good_clr),
    .hit (good_hit)
  );

  freq_run_counter #(
    .THRESH(BAD_CNT)
  ) u_bad_run (
    .clk (clk),
    .nrst(nrst),
    .inc (bad_inc),
    .clr (bad_clr),
    .hit (bad_hit)
  );

  // Cycles since the last strobe; idle in IDLE, held at TIMEOUT once stalled.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tmo_q <= '0;
    end else if (clear || readout_strb || (state_q == IDLE)) begin
      tmo_q <= '0;
    end else if (state_q == STALLED) begin
      if (tmo_q < TmoSat) tmo_q <= tmo_q + CNT_W'(1);
    end else begin
      tmo_q <= tmo_q + CNT_W'(1);
    end
  end

  // Lock FSM with registered status outputs and min/max tracking.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= IDLE;
      raw_low_q      <= 1'b0;
      freq_ok        <= 1'b0;
      freq_low       <= 1'b0;
      freq_high      <= 1'b0;
      stalled        <= 1'b0;
      lock_lost_strb <= 1'b0;
      min_cnt        <= '1;
      max_cnt        <= '0;
    end else begin
      lock_lost_strb <= 1'b0;
      if (clear) begin
        // Any exit from LOCKED is reported, including a clear.
        lock_lost_strb <= (state_q == LOCKED);
        state_q        <= IDLE;
        freq_ok        <= 1'b0;
        stalled        <= 1'b0;
        freq_low       <= raw_low_q;
        min_cnt        <= '1;
        max_cnt        <= '0;
      end else if (strb) begin
        raw_low_q <= below;
        freq_low  <= below;
        freq_high <= above;
        stalled   <= 1'b0;
        if (readout < min_cnt) min_cnt <= readout;
        if (readout > max_cnt) max_cnt <= readout;
        unique case (state_q)
          IDLE, ACQUIRE, STALLED: begin
            state_q <= good_hit ? LOCKED : ACQUIRE;
            freq_ok <= good_hit;
          end
          LOCKED: begin
            if (bad_hit) begin
              state_q        <= ACQUIRE;
              freq_ok        <= 1'b0;
              lock_lost_strb <= 1'b1;
            end
          end
        endcase
      end else if (stall_go) begin
        lock_lost_strb <= (state_q == LOCKED);
        state_q        <= STALLED;
        freq_ok        <= 1'b0;
        stalled        <= 1'b1;
        freq_low       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_checker.sv
// Self-checking bench: two checkers (LOW_LIMIT 1000 and 20) share stimulus and
// are compared every cycle against a sample-level behavioural model.
module tb_freq_meter_checker;

  localparam int unsigned LOWP [2] = '{1000, 20};
  localparam longint      HIGHP    = 2000;
  localparam longint      HYSTP    = 50;
  localparam int          GOODP    = 3;
  localparam int          BADP     = 2;
  localparam int          TMOP     = 100;

  localparam int ST_IDLE = 0, ST_ACQ = 1, ST_LOCK = 2, ST_STALL = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic        clear;
  logic [31:0] readout;
  logic        readout_strb;

  logic        ok [2];
  logic        low [2];
  logic        high [2];
  logic        stl [2];
  logic        lost [2];
  logic [31:0] mn [2];
  logic [31:0] mx [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state, one set per checker.
  int          m_st [2];
  int          m_good [2];
  int          m_bad [2];
  int          m_since [2];
  bit          m_rlow [2];
  bit          m_high [2];
  bit          m_lost [2];
  logic [31:0] m_min [2];
  logic [31:0] m_max [2];

  always #5 clk = ~clk;

  freq_meter_checker #(
    .LOW_LIMIT(32'd1000), .HIGH_LIMIT(32'd2000), .HYST(32'd50),
    .GOOD_CNT(3), .BAD_CNT(2), .TIMEOUT(100)
  ) dut (
    .clk(clk), .nrst(nrst), .clear(clear), .readout(readout), .readout_strb(readout_strb),
    .freq_ok(ok[0]), .freq_low(low[0]), .freq_high(high[0]), .stalled(stl[0]),
    .lock_lost_strb(lost[0]), .min_cnt(mn[0]), .max_cnt(mx[0])
  );

  freq_meter_checker #(
    .LOW_LIMIT(32'd20), .HIGH_LIMIT(32'd2000), .HYST(32'd50),
    .GOOD_CNT(3), .BAD_CNT(2), .TIMEOUT(100)
  ) dut_lo (
    .clk(clk), .nrst(nrst), .clear(clear), .readout(readout), .readout_strb(readout_strb),
    .freq_ok(ok[1]), .freq_low(low[1]), .freq_high(high[1]), .stalled(stl[1]),
    .lock_lost_strb(lost[1]), .min_cnt(mn[1]), .max_cnt(mx[1])
  );

  task automatic cmp(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_st[k] = ST_IDLE; m_good[k] = 0; m_bad[k] = 0; m_since[k] = 0;
    m_rlow[k] = 0; m_high[k] = 0; m_lost[k] = 0;
    m_min[k] = 32'hFFFF_FFFF; m_max[k] = 32'h0;
  endtask

  // One clock of the lock rules, applied to the inputs sampled at this edge.
  task automatic model_step(input int k);
    longint r, wlo, whi;
    bit in_raw, in_hyst;
    r = longint'(readout);
    wlo = longint'(LOWP[k]) - HYSTP;
    if (wlo < 0) wlo = 0;
    whi = HIGHP + HYSTP;
    if (whi > 64'hFFFF_FFFF) whi = 64'hFFFF_FFFF;
    in_raw  = (r >= longint'(LOWP[k])) && (r <= HIGHP);
    in_hyst = (r >= wlo) && (r <= whi);
    m_lost[k] = 0;
    if (clear) begin
      if (m_st[k] == ST_LOCK) m_lost[k] = 1;
      m_st[k] = ST_IDLE; m_good[k] = 0; m_bad[k] = 0; m_since[k] = 0;
      m_min[k] = 32'hFFFF_FFFF; m_max[k] = 32'h0;
    end else if (readout_strb) begin
      m_since[k] = 0;
      m_rlow[k]  = r < longint'(LOWP[k]);
      m_high[k]  = r > HIGHP;
      if (readout < m_min[k]) m_min[k] = readout;
      if (readout > m_max[k]) m_max[k] = readout;
      if (m_st[k] != ST_LOCK) begin
        m_good[k] = in_raw ? m_good[k] + 1 : 0;
        if (m_good[k] >= GOODP) begin
          m_st[k] = ST_LOCK; m_good[k] = 0; m_bad[k] = 0;
        end else begin
          m_st[k] = ST_ACQ;
        end
      end else begin
        m_bad[k] = in_hyst ? 0 : m_bad[k] + 1;
        if (m_bad[k] >= BADP) begin
          m_st[k] = ST_ACQ; m_lost[k] = 1; m_bad[k] = 0; m_good[k] = 0;
        end
      end
    end else if (m_st[k] == ST_ACQ || m_st[k] == ST_LOCK) begin
      m_since[k]++;
      if (m_since[k] >= TMOP) begin
        if (m_st[k] == ST_LOCK) m_lost[k] = 1;
        m_st[k] = ST_STALL; m_good[k] = 0; m_bad[k] = 0;
      end
    end
  endtask

  always @(posedge clk or negedge nrst) begin
    for (int k = 0; k < 2; k++) begin
      if (!nrst) model_reset(k);
      else       model_step(k);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        cmp("freq_ok", k, 32'(ok[k]), 32'(m_st[k] == ST_LOCK));
        cmp("stalled", k, 32'(stl[k]), 32'(m_st[k] == ST_STALL));
        cmp("freq_low", k, 32'(low[k]), 32'(m_rlow[k] || (m_st[k] == ST_STALL)));
        cmp("freq_high", k, 32'(high[k]), 32'(m_high[k]));
        cmp("lock_lost_strb", k, 32'(lost[k]), 32'(m_lost[k]));
        cmp("min_cnt", k, mn[k], m_min[k]);
        cmp("max_cnt", k, mx[k], m_max[k]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle strobe; returns on the negedge where its result is visible.
  task automatic strobe(input logic [31:0] v, input bit c);
    @(negedge clk);
    readout = v; readout_strb = 1'b1; clear = c;
    @(negedge clk);
    readout_strb = 1'b0; clear = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    int c;
    c = $urandom_range(0, 15);
    case (c)
      0:       return $urandom;
      1:       return 32'd0;
      2:       return $urandom_range(940, 1010);
      3:       return $urandom_range(1990, 2060);
      4:       return $urandom_range(0, 30);
      5:       return 32'hFFFF_FFFF;
      default: return $urandom_range(1000, 2000);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; clear = 1'b0; readout = '0; readout_strb = 1'b0;
    idle(2);
    // Reset values.
    cmp("rst_ok", 0, 32'(ok[0]), 32'd0);
    cmp("rst_low", 0, 32'(low[0]), 32'd0);
    cmp("rst_stalled", 0, 32'(stl[0]), 32'd0);
    cmp("rst_min", 0, mn[0], 32'hFFFF_FFFF);
    cmp("rst_max", 0, mx[0], 32'h0);
    #2 nrst = 1'b1;
    chk_en = 1'b1;

    // Lock after three in-range samples.
    strobe(1500, 0); idle(8);
    strobe(1500, 0); idle(8);
    cmp("pre_lock_ok", 0, 32'(ok[0]), 32'd0);
    strobe(1500, 0);
    cmp("lock_ok", 0, 32'(ok[0]), 32'd1);
    cmp("lock_low", 0, 32'(low[0]), 32'd0);
    cmp("lock_high", 0, 32'(high[0]), 32'd0);
    cmp("lock_min", 0, mn[0], 32'd1500);
    cmp("lock_max", 0, mx[0], 32'd1500);

    // Hysteresis: 2040 holds lock, two 2060s drop it.
    idle(8); strobe(2040, 0); idle(8); strobe(2040, 0);
    cmp("hyst_hold_ok", 0, 32'(ok[0]), 32'd1);
    idle(8); strobe(2060, 0);
    cmp("hyst_first_high", 0, 32'(high[0]), 32'd1);
    cmp("hyst_first_ok", 0, 32'(ok[0]), 32'd1);
    idle(8); strobe(2060, 0);
    cmp("hyst_lost_ok", 0, 32'(ok[0]), 32'd0);
    cmp("hyst_lost_strb", 0, 32'(lost[0]), 32'd1);
    idle(1);
    cmp("hyst_lost_pulse_end", 0, 32'(lost[0]), 32'd0);

    // An out-of-range sample restarts qualification.
    strobe(1500, 0); idle(8); strobe(1500, 0); idle(8); strobe(900, 0); idle(8);
    strobe(1500, 0); idle(8); strobe(1500, 0);
    cmp("qual_no_lock", 0, 32'(ok[0]), 32'd0);
    idle(8); strobe(1500, 0);
    cmp("qual_lock", 0, 32'(ok[0]), 32'd1);
    cmp("qual_min", 0, mn[0], 32'd900);

    // Stall after TIMEOUT cycles without a strobe.
    idle(99);
    cmp("stall_early", 0, 32'(stl[0]), 32'd0);
    idle(1);
    cmp("stall_flag", 0, 32'(stl[0]), 32'd1);
    cmp("stall_low", 0, 32'(low[0]), 32'd1);
    cmp("stall_ok", 0, 32'(ok[0]), 32'd0);
    cmp("stall_lost", 0, 32'(lost[0]), 32'd1);
    strobe(1500, 0);
    cmp("unstall_flag", 0, 32'(stl[0]), 32'd0);
    cmp("unstall_low", 0, 32'(low[0]), 32'd0);
    idle(8); strobe(1500, 0); idle(8); strobe(1500, 0);
    cmp("relock_after_stall", 0, 32'(ok[0]), 32'd1);

    // Strobe on the expiry cycle prevents the stall.
    idle(98); strobe(1500, 0);
    cmp("collide_stalled", 0, 32'(stl[0]), 32'd0);
    cmp("collide_ok", 0, 32'(ok[0]), 32'd1);
    idle(1);
    cmp("collide_stalled_after", 0, 32'(stl[0]), 32'd0);

    // Clear beats a coincident strobe.
    strobe(5, 1);
    cmp("clear_ok", 0, 32'(ok[0]), 32'd0);
    cmp("clear_min", 0, mn[0], 32'hFFFF_FFFF);
    cmp("clear_max", 0, mx[0], 32'h0);
    cmp("clear_low", 0, 32'(low[0]), 32'd0);
    idle(150);
    cmp("idle_no_stall", 0, 32'(stl[0]), 32'd0);

    // Window edges are in range; saturated low bound keeps checker 1 locked at 0.
    strobe(1000, 0); idle(8); strobe(2000, 0); idle(8); strobe(1000, 0);
    cmp("edge_lock", 0, 32'(ok[0]), 32'd1);
    cmp("edge_min", 0, mn[0], 32'd1000);
    cmp("edge_max", 0, mx[0], 32'd2000);
    cmp("edge_lock_lo", 1, 32'(ok[1]), 32'd1);
    idle(8); strobe(0, 0);
    cmp("zero_lo_ok", 1, 32'(ok[1]), 32'd1);
    cmp("zero_lo_low", 1, 32'(low[1]), 32'd1);
    idle(8); strobe(0, 0);
    cmp("zero_ok", 0, 32'(ok[0]), 32'd0);
    cmp("zero_lost", 0, 32'(lost[0]), 32'd1);
    cmp("zero_lo_hold", 1, 32'(ok[1]), 32'd1);
    cmp("zero_lo_nolost", 1, 32'(lost[1]), 32'd0);

    // Asynchronous reset while locked.
    @(posedge clk); #2 nrst = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      cmp("arst_ok", k, 32'(ok[k]), 32'd0);
      cmp("arst_low", k, 32'(low[k]), 32'd0);
      cmp("arst_lost", k, 32'(lost[k]), 32'd0);
      cmp("arst_min", k, mn[k], 32'hFFFF_FFFF);
    end
    @(negedge clk); #2 nrst = 1'b1;
    idle(1);
    cmp("arst_lost_after", 0, 32'(lost[0]), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int g;
      g = $urandom_range(0, 99);
      if (g < 3) begin
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
      end
      strobe(pick_val(), $urandom_range(0, 49) == 0);
      if (g >= 94) idle($urandom_range(95, 104));
      else         idle($urandom_range(0, 12));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
